// File: rtl/seq_gen_if.sv
// seq_gen_if: command, table-config and status signals of seq_gen_ctrl
interface seq_gen_if #(parameter int W = 3, parameter int AW = 2);
    logic          start, pause, stop, cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_data, out;
    logic [AW:0]   cfg_len;
    logic [7:0]    cfg_reps;
    logic          out_valid, busy, done, cfg_err;
    modport master (output start, pause, stop, cfg_we, cfg_addr, cfg_data, cfg_len, cfg_reps,
                    input  out, out_valid, busy, done, cfg_err);
    modport slave  (input  start, pause, stop, cfg_we, cfg_addr, cfg_data, cfg_len, cfg_reps,
                    output out, out_valid, busy, done, cfg_err);
endinterface

// File: rtl/seq_gen_ctrl.sv
// seq_gen_ctrl: plays a programmable pattern table for a set number of passes,
// with pause/resume/stop control and write protection while busy.
module seq_gen_ctrl #(parameter int DEPTH = 4, parameter int W = 3, parameter int AW = 2) (
    input logic clk,
    input logic rst,
    seq_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t        state;
    logic [W-1:0]  tab [DEPTH];
    logic [W-1:0]  run_tab [DEPTH];
    logic [AW-1:0] idx;
    logic [AW:0]   len, len_eff;
    logic [7:0]    pass, reps;
    logic          last_ent, last_pass, wr_ok;
    function automatic logic [W-1:0] def_val(input int i);
        return i == 0 ? W'(0) : i == 1 ? W'(2) : i == 2 ? W'(3) : i == 3 ? W'(5) : W'(0);
    endfunction
    always_comb begin
        len_eff   = (bus.cfg_len == '0 || bus.cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.cfg_len;
        last_ent  = {1'b0, idx} == len - (AW+1)'(1);
        last_pass = reps != 8'd0 && pass + 8'd1 == reps;
        wr_ok     = bus.cfg_we && !bus.busy && 32'(bus.cfg_addr) < DEPTH;
    end
    // run_tab is snapshotted at launch so a coincident write only affects later runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            pass          <= '0;
            len           <= (AW+1)'(DEPTH);
            reps          <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.cfg_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tab[i]     <= def_val(i);
                run_tab[i] <= def_val(i);
            end
        end else begin
            bus.done      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.cfg_err   <= bus.cfg_we && bus.busy;
            if (wr_ok) tab[bus.cfg_addr] <= bus.cfg_data;
            if (bus.stop) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        bus.done <= state == DONE;
                        state    <= bus.start ? RUN : IDLE;
                        bus.busy <= bus.start;
                        if (bus.start) begin
                            idx     <= '0;
                            pass    <= '0;
                            len     <= len_eff;
                            reps    <= bus.cfg_reps;
                            run_tab <= tab;
                        end
                    end
                    RUN: begin
                        if (bus.pause && !bus.start) state <= PAUSE;
                        else begin
                            bus.out       <= run_tab[idx];
                            bus.out_valid <= 1'b1;
                            idx           <= last_ent ? '0 : idx + AW'(1);
                            if (last_ent) begin
                                pass <= pass == 8'hff ? pass : pass + 8'd1;
                                if (last_pass) begin
                                    state    <= DONE;
                                    bus.busy <= 1'b0;
                                end
                            end
                        end
                    end
                    PAUSE: state <= bus.start ? RUN : PAUSE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq_gen_ctrl.sv
// tb_seq_gen_ctrl: directed checks of seq_gen_ctrl run, pause, stop, write protection and reset
module tb_seq_gen_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    logic [2:0] exp_v [$];
    seq_gen_if #(.W(3), .AW(2)) bus ();
    seq_gen_ctrl #(.DEPTH(4), .W(3), .AW(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [2:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        tick();
        bus.cfg_we = 1'b0;
        chk("wr_idle_no_err", bus.cfg_err, 0);
    endtask

    task automatic launch(input logic [2:0] len, input logic [7:0] reps);
        bus.cfg_len = len; bus.cfg_reps = reps; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("launch_busy", bus.busy, 1);
        chk("launch_no_valid", bus.out_valid, 0);
    endtask

    // expects the elements in exp_v, then a one-cycle done pulse, then idle
    task automatic run_seq(input string tag, input logic [2:0] len, input logic [7:0] reps);
        launch(len, reps);
        for (int i = 0; i < exp_v.size(); i++) begin
            tick();
            chk({tag, "_valid"}, bus.out_valid, 1);
            chk({tag, "_out"}, bus.out, exp_v[i]);
        end
        tick();
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_done_novalid"}, bus.out_valid, 0);
        tick();
        chk({tag, "_done_once"}, bus.done, 0);
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        {bus.start, bus.pause, bus.stop, bus.cfg_we} = '0;
        bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_len = 3'd4; bus.cfg_reps = 8'd1;
        #2 rst = 1'b1;
        #1;
        chk("rst_out", bus.out, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.cfg_err, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        exp_v = '{0, 2, 3, 5};
        run_seq("default", 3'd4, 8'd1);

        wr(0, 1); wr(1, 4); wr(2, 6); wr(3, 7);
        exp_v = '{1, 4, 6, 1, 4, 6};
        run_seq("len3_reps2", 3'd3, 8'd2);

        wr(0, 0); wr(1, 2); wr(2, 3); wr(3, 5);
        launch(3'd4, 8'd1);
        tick(); chk("pz_e0", bus.out, 0);
        tick(); chk("pz_e1", bus.out, 2);
        bus.pause = 1'b1;
        tick();
        bus.pause = 1'b0;
        chk("pz_hold1_valid", bus.out_valid, 0); chk("pz_hold1_out", bus.out, 2);
        tick();
        chk("pz_hold2_valid", bus.out_valid, 0); chk("pz_hold2_out", bus.out, 2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("pz_hold3_valid", bus.out_valid, 0); chk("pz_hold3_out", bus.out, 2);
        chk("pz_busy", bus.busy, 1);
        tick(); chk("pz_e2_valid", bus.out_valid, 1); chk("pz_e2", bus.out, 3);
        tick(); chk("pz_e3", bus.out, 5);
        tick(); chk("pz_done", bus.done, 1);

        launch(3'd4, 8'd0);
        exp_v = '{0, 2, 3, 5};
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("inf_valid", bus.out_valid, 1);
            chk("inf_out", bus.out, exp_v[i % 4]);
        end
        bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        chk("stop_valid", bus.out_valid, 0);
        chk("stop_busy", bus.busy, 0);
        chk("stop_nodone", bus.done, 0);
        chk("stop_hold", bus.out, 3);
        tick();
        chk("stop_nodone2", bus.done, 0);
        chk("stop_no_relaunch", bus.busy, 0);

        launch(3'd4, 8'd2);
        tick(); chk("we_run_e0", bus.out, 0);
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_data = 3'd7;
        tick();
        bus.cfg_we = 1'b0;
        chk("we_run_err", bus.cfg_err, 1);
        chk("we_run_e1", bus.out, 2);
        tick();
        chk("we_run_err_once", bus.cfg_err, 0);
        exp_v = '{3, 5, 0, 2, 3, 5};
        for (int i = 0; i < exp_v.size(); i++) begin
            if (i > 0) tick();
            chk("we_run_seq", bus.out, exp_v[i]);
        end
        tick(); chk("we_run_done", bus.done, 1);
        tick();
        wr(1, 7);
        exp_v = '{0, 7, 3, 5};
        run_seq("we_idle", 3'd4, 8'd1);

        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 3'd6;
        launch(3'd4, 8'd1);
        bus.cfg_we = 1'b0;
        chk("wr_launch_no_err", bus.cfg_err, 0);
        exp_v = '{0, 7, 3, 5};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wr_launch_old", bus.out, exp_v[i]);
        end
        tick(); chk("wr_launch_done", bus.done, 1);
        tick();
        exp_v = '{6, 7, 3, 5};
        run_seq("len0_full", 3'd0, 8'd1);
        run_seq("len7_full", 3'd7, 8'd1);

        launch(3'd4, 8'd0);
        tick(); tick(); tick();
        chk("mid_pre_rst", bus.out, 3);
        #3 rst = 1'b1;
        #1;
        chk("arst_out", bus.out, 0);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        tick();
        rst = 1'b0;
        tick();
        exp_v = '{0, 2, 3, 5};
        run_seq("post_rst", 3'd4, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
